// File: rtl/axi_rd_arb_pkg.sv
// Shared types, defaults and helper functions for the AXI read arbiter slice.
package axi_rd_arb_pkg;

    localparam int unsigned C_REQ_NUM_DEF         = 32'd4;
    localparam int unsigned C_AXI_ADDR_WIDTH_DEF  = 32'd32;
    localparam int unsigned C_USER_DATA_WIDTH_DEF = 32'd16;
    localparam int unsigned C_ORDER_DEPTH_DEF     = 32'd8;
    localparam int unsigned C_REQ_MAX             = 32'd8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_e;

    function automatic int unsigned tag_width(input int unsigned req_num);
        return (req_num > 32'd1) ? $clog2(req_num) : 32'd1;
    endfunction

    // First valid requester after 'last', wrapping modulo req_num.
    function automatic int unsigned rr_pick(input logic [C_REQ_MAX-1:0] valid,
                                            input int unsigned last,
                                            input int unsigned req_num);
        int unsigned idx;
        int unsigned pick;
        logic        found;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 32'd1; i <= C_REQ_MAX; i++) begin
            idx = (last + i) % req_num;
            if (!found && (i <= req_num) && valid[idx[2:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_fifo.sv
// First-word-fall-through tag FIFO holding the owner of each outstanding burst.
module sync_tag_fifo #(
    parameter int unsigned P_WIDTH = 32'd2,
    parameter int unsigned P_DEPTH = 32'd8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [P_WIDTH-1:0]         i_din,
    input  logic                       i_pop,
    output logic [P_WIDTH-1:0]         o_dout,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(P_DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = (P_DEPTH > 32'd1) ? $clog2(P_DEPTH) : 32'd1;
    localparam int unsigned CNT_W = $clog2(P_DEPTH) + 32'd1;

    logic [P_WIDTH-1:0] mem_r [P_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               do_push_s;
    logic               do_pop_s;

    // Overflow/underflow guards
    always_comb begin
        do_push_s = i_push && (count_r != CNT_W'(P_DEPTH));
        do_pop_s  = i_pop && (count_r != {CNT_W{1'b0}});
    end

    // Storage, pointers and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < P_DEPTH; i++) begin
                mem_r[i] <= {P_WIDTH{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= i_din;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign o_dout  = mem_r[rd_ptr_r];
    assign o_empty = (count_r == {CNT_W{1'b0}});
    assign o_full  = (count_r == CNT_W'(P_DEPTH));
    assign o_count = count_r;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin sharing of one AXI read master; return beats steered by an in-order tag queue.
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int unsigned P_REQ_NUM         = C_REQ_NUM_DEF,
    parameter int unsigned P_AXI_ADDR_WIDTH  = C_AXI_ADDR_WIDTH_DEF,
    parameter int unsigned P_USER_DATA_WIDTH = C_USER_DATA_WIDTH_DEF,
    parameter int unsigned P_ORDER_DEPTH     = C_ORDER_DEPTH_DEF
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [P_REQ_NUM-1:0]                  i_req_valid,
    output logic [P_REQ_NUM-1:0]                  o_req_ready,
    input  logic [P_REQ_NUM*P_AXI_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [P_REQ_NUM*8-1:0]                i_req_length,
    output logic                                  o_u2a_valid,
    input  logic                                  i_axi_ready,
    output logic [P_AXI_ADDR_WIDTH-1:0]           o_u2a_addr,
    output logic [7:0]                            o_u2a_length,
    input  logic [P_USER_DATA_WIDTH-1:0]          i_user_data,
    input  logic                                  i_user_valid,
    input  logic                                  i_user_last,
    output logic [P_USER_DATA_WIDTH-1:0]          o_rd_data,
    output logic [P_REQ_NUM-1:0]                  o_rd_valid,
    output logic [P_REQ_NUM-1:0]                  o_rd_last,
    output logic [$clog2(P_ORDER_DEPTH):0]        o_outstanding,
    output logic                                  o_err_orphan
);

    localparam int unsigned TAG_W = tag_width(P_REQ_NUM);
    localparam int unsigned CNT_W = $clog2(P_ORDER_DEPTH) + 32'd1;
    localparam logic [P_REQ_NUM-1:0] REQ_ONE = {{(P_REQ_NUM-1){1'b0}}, 1'b1};

    logic [1:0]                   rst_sync_r;
    logic                         rst_n_s;
    arb_state_e                   state_r;
    logic [TAG_W-1:0]             last_r;
    logic [TAG_W-1:0]             tag_r;
    logic [P_AXI_ADDR_WIDTH-1:0]  addr_r;
    logic [7:0]                   len_r;
    logic [P_USER_DATA_WIDTH-1:0] rd_data_r;
    logic [P_REQ_NUM-1:0]         rd_valid_r;
    logic [P_REQ_NUM-1:0]         rd_last_r;
    logic                         orphan_r;
    logic [C_REQ_MAX-1:0]         req_valid_ext_s;
    logic [TAG_W-1:0]             win_tag_s;
    logic [P_AXI_ADDR_WIDTH-1:0]  win_addr_s;
    logic [7:0]                   win_len_s;
    logic                         accept_s;
    logic                         push_s;
    logic                         pop_s;
    logic                         beat_ok_s;
    logic [TAG_W-1:0]             head_tag_s;
    logic                         fifo_empty_s;
    logic                         fifo_full_s;
    logic [CNT_W-1:0]             count_s;

    // Asynchronous assert, two-flop synchronous release
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    // Winner selection, grant and queue handshakes
    always_comb begin
        req_valid_ext_s                = {C_REQ_MAX{1'b0}};
        req_valid_ext_s[P_REQ_NUM-1:0] = i_req_valid;
        win_tag_s  = TAG_W'(rr_pick(req_valid_ext_s, 32'(last_r), P_REQ_NUM));
        win_addr_s = {P_AXI_ADDR_WIDTH{1'b0}};
        win_len_s  = 8'd0;
        for (int k = 0; k < P_REQ_NUM; k++) begin
            win_addr_s = (win_tag_s == TAG_W'(k)) ?
                         i_req_addr[k*P_AXI_ADDR_WIDTH +: P_AXI_ADDR_WIDTH] : win_addr_s;
            win_len_s  = (win_tag_s == TAG_W'(k)) ? i_req_length[k*8 +: 8] : win_len_s;
        end
        accept_s    = rst_n_s && (state_r == ST_IDLE) && (|i_req_valid) && !fifo_full_s;
        o_req_ready = accept_s ? (REQ_ONE << win_tag_s) : {P_REQ_NUM{1'b0}};
        push_s      = (state_r == ST_ISSUE) && i_axi_ready;
        beat_ok_s   = i_user_valid && !fifo_empty_s;
        pop_s       = beat_ok_s && i_user_last;
    end

    // Command FSM: one outstanding command on the master port at a time
    always_ff @(posedge i_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r <= ST_IDLE;
            last_r  <= TAG_W'(P_REQ_NUM - 32'd1);
            tag_r   <= {TAG_W{1'b0}};
            addr_r  <= {P_AXI_ADDR_WIDTH{1'b0}};
            len_r   <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r <= ST_ISSUE;
                        tag_r   <= win_tag_s;
                        addr_r  <= win_addr_s;
                        len_r   <= win_len_s;
                    end
                end
                ST_ISSUE: begin
                    if (push_s) begin
                        state_r <= ST_IDLE;
                        last_r  <= tag_r;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Return path: beats go to the oldest outstanding owner, orphans are sticky
    always_ff @(posedge i_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            rd_data_r  <= {P_USER_DATA_WIDTH{1'b0}};
            rd_valid_r <= {P_REQ_NUM{1'b0}};
            rd_last_r  <= {P_REQ_NUM{1'b0}};
            orphan_r   <= 1'b0;
        end else begin
            rd_valid_r <= beat_ok_s ? (REQ_ONE << head_tag_s) : {P_REQ_NUM{1'b0}};
            rd_last_r  <= pop_s ? (REQ_ONE << head_tag_s) : {P_REQ_NUM{1'b0}};
            if (beat_ok_s) begin
                rd_data_r <= i_user_data;
            end
            orphan_r   <= orphan_r | (i_user_valid & fifo_empty_s);
        end
    end

    sync_tag_fifo #(
        .P_WIDTH (TAG_W),
        .P_DEPTH (P_ORDER_DEPTH)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst_n (rst_n_s),
        .i_push  (push_s),
        .i_din   (tag_r),
        .i_pop   (pop_s),
        .o_dout  (head_tag_s),
        .o_empty (fifo_empty_s),
        .o_full  (fifo_full_s),
        .o_count (count_s)
    );

    assign o_u2a_valid   = (state_r == ST_ISSUE);
    assign o_u2a_addr    = addr_r;
    assign o_u2a_length  = len_r;
    assign o_rd_data     = rd_data_r;
    assign o_rd_valid    = rd_valid_r;
    assign o_rd_last     = rd_last_r;
    assign o_outstanding = count_s;
    assign o_err_orphan  = orphan_r;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_axi_rd_arbiter;

    localparam int N     = 4;
    localparam int AW    = 32;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic [N-1:0]    i_req_valid;
    logic [N-1:0]    o_req_ready;
    logic [N*AW-1:0] i_req_addr;
    logic [N*8-1:0]  i_req_length;
    logic            o_u2a_valid;
    logic            i_axi_ready;
    logic [AW-1:0]   o_u2a_addr;
    logic [7:0]      o_u2a_length;
    logic [DW-1:0]   i_user_data;
    logic            i_user_valid;
    logic            i_user_last;
    logic [DW-1:0]   o_rd_data;
    logic [N-1:0]    o_rd_valid;
    logic [N-1:0]    o_rd_last;
    logic [3:0]      o_outstanding;
    logic            o_err_orphan;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending command, round-robin pointer, owner queue
    int          m_pend;
    int          m_grant;
    int          m_last;
    int          m_q[$];
    logic [AW-1:0] m_addr;
    logic [7:0]  m_len;
    bit          m_orph;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    logic [N-1:0] exp_rl;
    logic [DW-1:0] exp_rd;

    always #5 i_clk = ~i_clk;

    axi_rd_arbiter #(
        .P_REQ_NUM(N), .P_AXI_ADDR_WIDTH(AW), .P_USER_DATA_WIDTH(DW), .P_ORDER_DEPTH(DEPTH)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_length(i_req_length), .o_u2a_valid(o_u2a_valid),
        .i_axi_ready(i_axi_ready), .o_u2a_addr(o_u2a_addr), .o_u2a_length(o_u2a_length),
        .i_user_data(i_user_data), .i_user_valid(i_user_valid), .i_user_last(i_user_last),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_rd_last(o_rd_last),
        .o_outstanding(o_outstanding), .o_err_orphan(o_err_orphan)
    );

    task automatic model_reset();
        m_pend = -1; m_grant = -1; m_last = N - 1; m_q.delete();
        m_addr = '0; m_len = '0; m_orph = 1'b0;
        exp_ready = '0; exp_rv = '0; exp_rl = '0; exp_rd = '0;
    endtask

    task automatic model_eval();
        int k;
        m_grant = -1;
        exp_ready = '0;
        if (m_pend < 0 && m_q.size() < DEPTH && i_req_valid != '0) begin
            for (int i = 1; i <= N; i++) begin
                k = (m_last + i) % N;
                if (i_req_valid[k]) begin
                    m_grant = k;
                    break;
                end
            end
        end
        if (m_grant >= 0) exp_ready[m_grant] = 1'b1;
    endtask

    task automatic tick();
        model_eval();
        @(posedge i_clk);
        exp_rv = '0;
        exp_rl = '0;
        if (i_user_valid) begin
            if (m_q.size() > 0) begin
                exp_rv[m_q[0]] = 1'b1;
                exp_rd = i_user_data;
                if (i_user_last) begin
                    exp_rl[m_q[0]] = 1'b1;
                    void'(m_q.pop_front());
                end
            end else begin
                m_orph = 1'b1;
            end
        end
        if (m_pend >= 0 && i_axi_ready) begin
            m_q.push_back(m_pend);
            m_last = m_pend;
            m_pend = -1;
        end else if (m_grant >= 0) begin
            m_pend = m_grant;
            m_addr = i_req_addr[m_grant*AW +: AW];
            m_len  = i_req_length[m_grant*8 +: 8];
        end
        @(negedge i_clk);
    endtask

    task automatic clear_inputs();
        i_req_valid = '0; i_axi_ready = 1'b0; i_user_valid = 1'b0; i_user_last = 1'b0;
        i_user_data = '0;
        for (int k = 0; k < N; k++) begin
            i_req_addr[k*AW +: AW]  = 32'h1000_0000 + 32'(k) * 32'h100;
            i_req_length[k*8 +: 8]  = 8'(k + 1);
        end
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        clear_inputs();
        i_req_valid = 4'b1111;
        #1;
        n_checks++;
        if (o_req_ready !== 4'b0000) begin
            n_errors++; $display("FAIL reset_ready got=%b exp=0000", o_req_ready);
        end
        do_reset();
        #1;
        n_checks++;
        if ({o_req_ready, o_u2a_valid, o_u2a_addr, o_u2a_length, o_rd_data, o_rd_valid,
             o_rd_last, o_outstanding, o_err_orphan} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs got ready=%b v=%b a=%h l=%h d=%h rv=%b rl=%b out=%0d orph=%b exp all zero",
                     o_req_ready, o_u2a_valid, o_u2a_addr, o_u2a_length, o_rd_data, o_rd_valid,
                     o_rd_last, o_outstanding, o_err_orphan);
        end
    endtask

    task automatic test_rr_order();
        int grants[$];
        int gcyc[$];
        int req;
        do_reset();
        i_req_valid = 4'b1111;
        i_axi_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            for (int k = 0; k < N; k++) begin
                if (o_req_ready[k]) begin
                    grants.push_back(k);
                    gcyc.push_back(c);
                end
            end
            if (c % 2 == 1) begin
                req = ((c - 1) / 2) % N;
                n_checks++;
                if (o_u2a_valid !== 1'b1 || o_u2a_addr !== 32'h1000_0000 + 32'(req) * 32'h100) begin
                    n_errors++;
                    $display("FAIL rr_addr cyc=%0d got v=%b a=%h exp v=1 a=%h", c, o_u2a_valid,
                             o_u2a_addr, 32'h1000_0000 + 32'(req) * 32'h100);
                end
            end
            tick();
        end
        n_checks++;
        if (grants.size() != 5) begin
            n_errors++; $display("FAIL rr_count got=%0d exp=5", grants.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (grants[i] != i % N || gcyc[i] != 2 * i) begin
                    n_errors++;
                    $display("FAIL rr_order idx=%0d got req=%0d cyc=%0d exp req=%0d cyc=%0d",
                             i, grants[i], gcyc[i], i % N, 2 * i);
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        i_req_valid = 4'b0010;
        #1;
        n_checks++;
        if (o_req_ready !== 4'b0010) begin
            n_errors++; $display("FAIL stall_grant got=%b exp=0010", o_req_ready);
        end
        tick();
        i_req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (o_u2a_valid !== 1'b1 || o_u2a_addr !== 32'h1000_0100 || o_u2a_length !== 8'd2 ||
                o_req_ready !== 4'b0000) begin
                n_errors++;
                $display("FAIL stall_hold cyc=%0d got v=%b a=%h l=%0d rdy=%b exp v=1 a=10000100 l=2 rdy=0000",
                         c, o_u2a_valid, o_u2a_addr, o_u2a_length, o_req_ready);
            end
            tick();
        end
        i_req_valid = 4'b0000;
        i_axi_ready = 1'b1;
        tick();
        #1;
        n_checks++;
        if (o_u2a_valid !== 1'b0 || o_outstanding !== 4'd1) begin
            n_errors++;
            $display("FAIL stall_release got v=%b out=%0d exp v=0 out=1", o_u2a_valid, o_outstanding);
        end
    endtask

    task automatic test_return_steer();
        logic [DW-1:0] d;
        logic [N-1:0]  ev;
        do_reset();
        for (int k = 0; k < N; k++) i_req_length[k*8 +: 8] = 8'd3;
        i_axi_ready = 1'b1;
        i_req_valid = 4'b0100;
        #1;
        n_checks++;
        if (o_req_ready !== 4'b0100) begin
            n_errors++; $display("FAIL steer_grant2 got=%b exp=0100", o_req_ready);
        end
        tick();
        i_req_valid = 4'b0001;
        tick();
        #1;
        n_checks++;
        if (o_req_ready !== 4'b0001) begin
            n_errors++; $display("FAIL steer_grant0 got=%b exp=0001", o_req_ready);
        end
        tick();
        i_req_valid = 4'b0000;
        tick();
        for (int b = 1; b <= 8; b++) begin
            d = 16'($urandom);
            i_user_valid = 1'b1;
            i_user_data  = d;
            i_user_last  = (b == 4 || b == 8);
            tick();
            ev = (b <= 4) ? 4'b0100 : 4'b0001;
            n_checks++;
            if (o_rd_valid !== ev || o_rd_last !== ((b == 4 || b == 8) ? ev : 4'b0000) ||
                o_rd_data !== d) begin
                n_errors++;
                $display("FAIL steer_beat b=%0d got rv=%b rl=%b d=%h exp rv=%b last=%0d d=%h",
                         b, o_rd_valid, o_rd_last, o_rd_data, ev, (b == 4 || b == 8), d);
            end
        end
        i_user_valid = 1'b0;
        i_user_last  = 1'b0;
        #1;
        n_checks++;
        if (o_outstanding !== 4'd0) begin
            n_errors++; $display("FAIL steer_drained got=%0d exp=0", o_outstanding);
        end
        tick();
        n_checks++;
        if (o_rd_valid !== 4'b0000) begin
            n_errors++; $display("FAIL steer_idle got=%b exp=0000", o_rd_valid);
        end
    endtask

    task automatic test_full();
        do_reset();
        i_req_valid = 4'b1111;
        i_axi_ready = 1'b1;
        repeat (16) tick();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (o_outstanding !== 4'd8 || o_req_ready !== 4'b0000 || o_u2a_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL full_hold cyc=%0d got out=%0d rdy=%b v=%b exp out=8 rdy=0000 v=0",
                         c, o_outstanding, o_req_ready, o_u2a_valid);
            end
            if (c < 2) tick();
        end
        i_user_valid = 1'b1;
        i_user_last  = 1'b1;
        i_user_data  = 16'hBEEF;
        tick();
        i_user_valid = 1'b0;
        i_user_last  = 1'b0;
        #1;
        n_checks++;
        if (o_outstanding !== 4'd7 || o_rd_valid !== 4'b0001 || o_rd_last !== 4'b0001 ||
            o_req_ready !== 4'b0001) begin
            n_errors++;
            $display("FAIL full_pop got out=%0d rv=%b rl=%b rdy=%b exp out=7 rv=0001 rl=0001 rdy=0001",
                     o_outstanding, o_rd_valid, o_rd_last, o_req_ready);
        end
        tick();
        tick();
        #1;
        n_checks++;
        if (o_outstanding !== 4'd8 || o_req_ready !== 4'b0000) begin
            n_errors++;
            $display("FAIL full_refill got out=%0d rdy=%b exp out=8 rdy=0000", o_outstanding, o_req_ready);
        end
    endtask

    task automatic test_orphan();
        do_reset();
        i_user_valid = 1'b1;
        i_user_data  = 16'h1234;
        #1;
        n_checks++;
        if (o_err_orphan !== 1'b0) begin
            n_errors++; $display("FAIL orphan_pre got=%b exp=0", o_err_orphan);
        end
        tick();
        i_user_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (o_err_orphan !== 1'b1 || o_rd_valid !== 4'b0000) begin
                n_errors++;
                $display("FAIL orphan_sticky cyc=%0d got orph=%b rv=%b exp orph=1 rv=0000",
                         c, o_err_orphan, o_rd_valid);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_req_valid = 4'b1111;
        i_axi_ready = 1'b1;
        repeat (7) tick();
        i_axi_ready = 1'b0;
        #1;
        n_checks++;
        if (o_u2a_valid !== 1'b1 || o_outstanding !== 4'd3) begin
            n_errors++;
            $display("FAIL midrst_pre got v=%b out=%0d exp v=1 out=3", o_u2a_valid, o_outstanding);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_u2a_valid !== 1'b0 || o_req_ready !== 4'b0000 || o_outstanding !== 4'd0 ||
            o_rd_valid !== 4'b0000) begin
            n_errors++;
            $display("FAIL midrst_async got v=%b rdy=%b out=%0d rv=%b exp all zero",
                     o_u2a_valid, o_req_ready, o_outstanding, o_rd_valid);
        end
        clear_inputs();
        model_reset();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        i_req_valid = 4'b1111;
        #1;
        n_checks++;
        if (o_req_ready !== 4'b0001 || o_outstanding !== 4'd0) begin
            n_errors++;
            $display("FAIL midrst_regrant got rdy=%b out=%0d exp rdy=0001 out=0", o_req_ready, o_outstanding);
        end
        tick();
        i_req_valid  = 4'b0000;
        i_user_valid = 1'b1;
        i_user_last  = 1'b1;
        tick();
        i_user_valid = 1'b0;
        i_user_last  = 1'b0;
        #1;
        n_checks++;
        if (o_err_orphan !== 1'b1 || o_rd_valid !== 4'b0000) begin
            n_errors++;
            $display("FAIL midrst_orphan got orph=%b rv=%b exp orph=1 rv=0000", o_err_orphan, o_rd_valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            i_req_valid = 4'($urandom_range(0, 15));
            for (int k = 0; k < N; k++) begin
                i_req_addr[k*AW +: AW] = 32'($urandom);
                i_req_length[k*8 +: 8] = 8'($urandom);
            end
            i_axi_ready = ($urandom_range(0, 9) < 7);
            if (m_q.size() > 0) i_user_valid = ($urandom_range(0, 9) < 6);
            else                i_user_valid = ($urandom_range(0, 199) == 0);
            i_user_last = ($urandom_range(0, 3) == 0);
            i_user_data = 16'($urandom);
            #1;
            model_eval();
            n_checks++;
            if (o_req_ready !== exp_ready || o_u2a_valid !== (m_pend >= 0) ||
                o_rd_valid !== exp_rv || o_rd_last !== exp_rl ||
                o_outstanding !== 4'(m_q.size()) || o_err_orphan !== m_orph) begin
                n_errors++;
                $display("FAIL rand_ctrl cyc=%0d got rdy=%b v=%b rv=%b rl=%b out=%0d orph=%b exp rdy=%b v=%0d rv=%b rl=%b out=%0d orph=%0d",
                         c, o_req_ready, o_u2a_valid, o_rd_valid, o_rd_last, o_outstanding, o_err_orphan,
                         exp_ready, (m_pend >= 0), exp_rv, exp_rl, m_q.size(), m_orph);
            end
            if (m_pend >= 0) begin
                n_checks++;
                if (o_u2a_addr !== m_addr || o_u2a_length !== m_len) begin
                    n_errors++;
                    $display("FAIL rand_cmd cyc=%0d got a=%h l=%0d exp a=%h l=%0d",
                             c, o_u2a_addr, o_u2a_length, m_addr, m_len);
                end
            end
            if (exp_rv != '0) begin
                n_checks++;
                if (o_rd_data !== exp_rd) begin
                    n_errors++;
                    $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, o_rd_data, exp_rd);
                end
            end
            tick();
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_rr_order();
        test_stall();
        test_return_steer();
        test_full();
        test_orphan();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Shares one AXI read master between P_REQ_NUM user requesters. Requests are taken in round-robin order and issued one at a time on the master's user command port (ready/valid/addr/length). The granted requester index is recorded in an in-order tag queue. Read data returned by the master is steered to the requester at the head of that queue, and the entry is popped on the beat marked last. The block sits in the AXI clock domain, between user clients and the read master.

## Interface
- P_REQ_NUM, 4, number of requesters (2..8)
- P_AXI_ADDR_WIDTH, 32, command address width
- P_USER_DATA_WIDTH, 16, returned data beat width
- P_ORDER_DEPTH, 8, tag-queue depth = max outstanding bursts (power of 2)

Ports:
- i_clk  in  1  single clock; all logic on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  P_REQ_NUM  per-requester command valid
- o_req_ready  out  P_REQ_NUM  per-requester accept, one-hot or zero
- i_req_addr  in  P_REQ_NUM*P_AXI_ADDR_WIDTH  packed addresses, requester k at slice k
- i_req_length  in  P_REQ_NUM*8  packed burst lengths (arlen encoding)
- o_u2a_valid  out  1  command valid to read master
- i_axi_ready  in  1  read master command ready
- o_u2a_addr  out  P_AXI_ADDR_WIDTH  command address
- o_u2a_length  out  8  command length
- i_user_data  in  P_USER_DATA_WIDTH  return beat from master
- i_user_valid  in  1  return beat valid
- i_user_last  in  1  last beat of a burst
- o_rd_data  out  P_USER_DATA_WIDTH  return data, shared by all requesters
- o_rd_valid  out  P_REQ_NUM  one-hot beat valid to owner
- o_rd_last  out  P_REQ_NUM  one-hot last to owner
- o_outstanding  out  $clog2(P_ORDER_DEPTH)+1  queued bursts
- o_err_orphan  out  1  sticky: beat arrived while queue empty

## Operation
- FSM has two states.
  - IDLE: if any i_req_valid and o_outstanding < P_ORDER_DEPTH:
    - compute RR winner w = first valid requester starting at r_last+1 (mod N);
    - o_req_ready[w]=1, combinational, this cycle only;
    - latch addr/len of w and tag w;
    - go to ISSUE.
  - ISSUE: o_u2a_valid=1 with latched addr/len.
    - On i_axi_ready: push tag into queue, r_last<=tag, go to IDLE.
    - Otherwise hold; addr/len stay stable.
- o_req_ready is 0 in ISSUE, and 0 in IDLE when the queue is full.
- Return path, per i_user_valid cycle:
  - queue non-empty: o_rd_valid[head]=1 and o_rd_data=i_user_data on the next cycle; o_rd_last[head]=i_user_last. If i_user_last, pop the head.
  - queue empty: beat dropped, o_err_orphan<=1 until reset.
- o_outstanding change per cycle: +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- Push when full cannot occur, because IDLE gates on count. Pop when empty is never performed.
- The return path has no backpressure; requesters must sink every beat.

## Timing
- Reset (async assert, synchronous release through a 2-flop deassert synchroniser) clears:
  - state to IDLE;
  - r_last to P_REQ_NUM-1, so requester 0 has top priority first;
  - queue and count to 0;
  - all outputs to 0, including o_err_orphan.
- Request accepted at cycle T; o_u2a_valid is high from T+1. Peak throughput is 1 command per 2 cycles.
- Return latency: i_user_valid at T gives o_rd_valid at T+1, registered. Data and last are registered alongside.
- A new command may issue in the same cycle a pop occurs, and the count stays consistent.
- Reset asserted mid-burst: outstanding tags are discarded. Beats after reset release raise o_err_orphan.

## Structure
- Package axi_rd_arb_pkg holds:
  - tag width function;
  - FSM state enum (IDLE, ISSUE);
  - default parameter constants.
- Sub-module sync_tag_fifo: single-clock FIFO of width $clog2(P_REQ_NUM), depth P_ORDER_DEPTH, first-word-fall-through, with count output.
- RR selection is a combinational function in the package.

## Test plan
- All 4 requesters valid from reset, i_axi_ready=1 -> grant order 0,1,2,3,0. o_u2a_addr matches each requester's address. Commands spaced 2 cycles apart.
- i_axi_ready held low 5 cycles in ISSUE -> o_u2a_valid and addr/len stable for 5 cycles. o_req_ready all 0 throughout.
- Issue bursts to requesters 2 then 0 with len 3 (4 beats); return 8 beats, last on beats 4 and 8 -> beats 1-4 on o_rd_valid[2], beats 5-8 on o_rd_valid[0]. o_rd_last pulses at beats 4 and 8.
- Issue 8 commands with no returns -> o_outstanding=8 and o_req_ready=0. One returned last in the same cycle as a pending valid -> one new request accepted, count returns to 8.
- Beat with empty queue -> no o_rd_valid, o_err_orphan=1 and held.
- Assert i_rst_n low in ISSUE with 3 outstanding -> all outputs 0 immediately. After release, o_outstanding=0 and first grant goes to requester 0.
